// File: rtl/pong_ball_engine.sv
// pong_ball_engine: frame-paced ball mover with paddle collision, speed ramp, pause and re-serve
module pong_ball_engine #(
  parameter int COORD_W            = 9,
  parameter int SCREEN_WIDTH       = 320,
  parameter int SCREEN_HEIGHT      = 240,
  parameter int BALL_SIZE          = 4,
  parameter int PADDLE_HEIGHT      = 48,
  parameter int LEFT_COLLISION     = 10,
  parameter int RIGHT_COLLISION    = 310,
  parameter int FRAME_RATE_COUNT   = 3333332,
  parameter int SPEED_W            = 3,
  parameter int MAX_SPEED          = 4,
  parameter int SERVE_DELAY_FRAMES = 60
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [2:0]         in_color,
  input  logic [COORD_W-1:0] paddle_left_y,
  input  logic [COORD_W-1:0] paddle_right_y,
  input  logic               pause,
  input  logic               m_ready,
  output logic               m_valid,
  output logic [COORD_W-1:0] box_x,
  output logic [COORD_W-1:0] box_y,
  output logic [2:0]         out_color,
  output logic [SPEED_W-1:0] ball_speed,
  output logic               left_point,
  output logic               right_point
);
  localparam int CW  = COORD_W + 1;
  localparam int FW  = $clog2(FRAME_RATE_COUNT + 1);
  localparam int SCW = $clog2(SERVE_DELAY_FRAMES + 1);
  localparam logic [COORD_W-1:0] X0 = COORD_W'((SCREEN_WIDTH - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] Y0 = COORD_W'((SCREEN_HEIGHT - BALL_SIZE) / 2);
  localparam logic [CW-1:0] B   = CW'(BALL_SIZE);
  localparam logic [CW-1:0] RC  = CW'(RIGHT_COLLISION);
  localparam logic [CW-1:0] LC  = CW'(LEFT_COLLISION);
  localparam logic [CW-1:0] SWD = CW'(SCREEN_WIDTH);
  localparam logic [CW-1:0] SHT = CW'(SCREEN_HEIGHT);
  localparam logic [CW-1:0] PH  = CW'(PADDLE_HEIGHT);

  typedef enum logic [1:0] {S_WAIT_TRANSACTION, S_WAIT_FRAME, S_UPDATE} state_t;

  state_t             state;
  logic [FW-1:0]      frame_cnt;
  logic [SCW-1:0]     serve_cnt;
  logic               vx_left, vy_up, vy_up_next;
  logic [CW-1:0]      x, y, s, nx, pl, pr;
  logic               cross_r, cross_l, hit_r, hit_l, score_l, score_r;
  logic [COORD_W-1:0] x_next, y_next;
  logic [SPEED_W-1:0] speed_inc;

  assign m_valid   = state == S_WAIT_TRANSACTION;
  assign out_color = in_color;

  // next-position candidates, all sums one bit wider than the coordinates so nothing wraps
  always_comb begin
    x          = CW'(box_x);
    y          = CW'(box_y);
    s          = CW'(ball_speed);
    nx         = x + s;
    pl         = CW'(paddle_left_y);
    pr         = CW'(paddle_right_y);
    cross_r    = !vx_left && (x + B <= RC) && (nx + B >= RC);
    cross_l    = vx_left && (x >= LC) && (x <= LC + s);
    hit_r      = cross_r && (y + B > pr) && (y < pr + PH);
    hit_l      = cross_l && (y + B > pl) && (y < pl + PH);
    score_l    = !vx_left && !cross_r && (nx + B >= SWD);
    score_r    = vx_left && !cross_l && (x <= s);
    x_next     = hit_r ? COORD_W'(RC - B) : hit_l ? COORD_W'(LC) : vx_left ? COORD_W'(x - s) : COORD_W'(nx);
    vy_up_next = vy_up ? (y != '0) : (y + B >= SHT);
    y_next     = vy_up_next ? box_y - COORD_W'(1) : box_y + COORD_W'(1);
    speed_inc  = (ball_speed >= SPEED_W'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED) : ball_speed + SPEED_W'(1);
  end

  // handshake / frame-wait / update sequencer owning all ball state
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_WAIT_TRANSACTION;
      box_x       <= X0;
      box_y       <= Y0;
      vx_left     <= 1'b0;
      vy_up       <= 1'b0;
      ball_speed  <= SPEED_W'(1);
      serve_cnt   <= '0;
      frame_cnt   <= '0;
      left_point  <= 1'b0;
      right_point <= 1'b0;
    end else begin
      left_point  <= 1'b0;
      right_point <= 1'b0;
      case (state)
        S_WAIT_TRANSACTION: begin
          frame_cnt <= '0;
          if (m_ready) state <= S_WAIT_FRAME;
        end
        S_WAIT_FRAME: begin
          if (frame_cnt != FW'(FRAME_RATE_COUNT)) frame_cnt <= frame_cnt + FW'(1);
          if (frame_cnt == FW'(FRAME_RATE_COUNT) && !pause) state <= S_UPDATE;
        end
        S_UPDATE: begin
          state <= S_WAIT_TRANSACTION;
          if (serve_cnt != '0) begin
            serve_cnt <= serve_cnt - SCW'(1);
          end else if (score_l || score_r) begin
            left_point  <= score_l;
            right_point <= score_r;
            box_x       <= X0;
            box_y       <= Y0;
            ball_speed  <= SPEED_W'(1);
            serve_cnt   <= SCW'(SERVE_DELAY_FRAMES);
            vx_left     <= score_l;
          end else begin
            box_x <= x_next;
            box_y <= y_next;
            vy_up <= vy_up_next;
            if (hit_r || hit_l) begin
              vx_left    <= hit_r;
              ball_speed <= speed_inc;
            end
          end
        end
        default: state <= S_WAIT_TRANSACTION;
      endcase
    end
  end
endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine: scoreboard bench driving frames and comparing each new ball position
module tb_pong_ball_engine;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] in_color = 3'd5;
  logic [8:0] paddle_left_y = '0, paddle_right_y = '0;
  logic       pause = 1'b0, m_ready = 1'b0;
  logic       m_valid, left_point, right_point;
  logic [8:0] box_x, box_y;
  logic [2:0] out_color;
  logic [2:0] ball_speed;

  pong_ball_engine #(.FRAME_RATE_COUNT(3)) dut (
    .clock(clock), .reset_n(reset_n), .in_color(in_color),
    .paddle_left_y(paddle_left_y), .paddle_right_y(paddle_right_y),
    .pause(pause), .m_ready(m_ready), .m_valid(m_valid),
    .box_x(box_x), .box_y(box_y), .out_color(out_color),
    .ball_speed(ball_speed), .left_point(left_point), .right_point(right_point)
  );

  // free-running clock
  always #5 clock = ~clock;

  typedef struct {int x; int y; int s; int lp; int rp;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int mx, my, mvx, mvy, ms, mserve, hits, points;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int track(input int yy);
    return yy > 20 ? yy - 20 : 0;
  endfunction

  function automatic int miss(input int yy);
    return yy >= 100 ? 0 : 200;
  endfunction

  task automatic model_reset();
    mx = 158; my = 118; mvx = 1; mvy = 1; ms = 1; mserve = 0;
    sb.delete();
  endtask

  task automatic model_step(input int pl, input int pr);
    exp_t e;
    int nx;
    int lp = 0, rp = 0;
    if (mserve > 0) mserve--;
    else begin
      if (mvx > 0) begin
        nx = mx + ms;
        if (mx + 4 <= 310 && nx + 4 >= 310) begin
          if (my + 4 > pr && my < pr + 48) begin mx = 306; mvx = -1; ms = ms < 4 ? ms + 1 : 4; hits++; end
          else mx = nx;
        end else if (nx + 4 >= 320) lp = 1;
        else mx = nx;
      end else begin
        if (mx >= 10 && mx <= 10 + ms) begin
          if (my + 4 > pl && my < pl + 48) begin mx = 10; mvx = 1; ms = ms < 4 ? ms + 1 : 4; hits++; end
          else mx = mx - ms;
        end else if (mx <= ms) rp = 1;
        else mx = mx - ms;
      end
      if (mvy > 0) begin
        if (my + 4 >= 240) begin my = my - 1; mvy = -1; end else my = my + 1;
      end else begin
        if (my == 0) begin my = 1; mvy = 1; end else my = my - 1;
      end
      if (lp || rp) begin
        mx = 158; my = 118; ms = 1; mserve = 60; mvx = lp ? -1 : 1; points++;
      end
    end
    e = '{mx, my, ms, lp, rp};
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; m_ready = 1'b0; pause = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    chk("rst_valid", m_valid, 1);
    chk("rst_x", box_x, 158);
    chk("rst_y", box_y, 118);
    chk("rst_speed", ball_speed, 1);
    chk("rst_lp", left_point, 0);
    chk("rst_rp", right_point, 0);
    chk("color", out_color, 5);
  endtask

  task automatic frame(input int pl, input int pr, input int stall, input bit pz);
    exp_t e;
    int cyc, px;
    paddle_left_y = 9'(pl); paddle_right_y = 9'(pr); m_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      chk("stall_valid", m_valid, 1);
      chk("stall_x", box_x, mx);
    end
    px = mx;
    model_step(pl, pr);
    m_ready = 1'b1;
    @(posedge clock);
    cyc = 0;
    if (pz) begin
      @(negedge clock);
      m_ready = 1'b0; pause = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        chk("pause_valid", m_valid, 0);
        chk("pause_x", box_x, px);
      end
      pause = 1'b0;
      cyc = 21;
    end
    do begin
      @(negedge clock);
      cyc++;
    end while (!m_valid && cyc < 60);
    m_ready = 1'b0;
    chk("period", cyc, pz ? 23 : 6);
    e = sb.pop_front();
    chk("box_x", box_x, e.x);
    chk("box_y", box_y, e.y);
    chk("speed", ball_speed, e.s);
    chk("left_point", left_point, e.lp);
    chk("right_point", right_point, e.rp);
    if (e.lp || e.rp) begin
      @(negedge clock);
      chk("lp_one_cycle", left_point, 0);
      chk("rp_one_cycle", right_point, 0);
    end
  endtask

  // stimulus and scoreboard sequence
  initial begin
    int n;
    hits = 0; points = 0;
    do_reset();
    frame(0, 0, 2, 0);
    n = 0;
    while (hits < 5 && n < 3000) begin
      frame(track(my), track(my), 0, 0);
      n++;
    end
    chk("speed_saturated", ball_speed, 4);
    n = 0;
    while (points < 2 && n < 3000) begin
      frame(miss(my), miss(my), 0, 0);
      n++;
    end
    for (int i = 0; i < 3; i++) frame(0, 0, 0, 0);
    do_reset();
    frame(0, 0, 0, 0);
    frame(track(my), track(my), 0, 1);
    frame(track(my), track(my), 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
